// File: rtl/if_id_queue.sv
// IF->ID decoupling queue: circular buffer of {pc, inst} entries with
// one-cycle latency, no bypass, flush that drops pointers, async reset.
module if_id_queue #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned INST_W = 32,
  parameter int unsigned DEPTH  = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [ADDR_W-1:0]          in_pc,
  input  logic [INST_W-1:0]          in_inst,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ADDR_W-1:0]          out_pc,
  output logic [INST_W-1:0]          out_inst,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } entry_t;

  entry_t             mem [DEPTH];
  entry_t             head;
  logic [PTR_W-1:0]   wp;
  logic [PTR_W-1:0]   rp;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_d;
  logic               push;
  logic               pop;

  // Handshake flags depend only on the registered count, never on the inputs
  // of the same cycle, so no combinational path crosses the queue.
  assign in_ready  = (cnt_q < CNT_W'(DEPTH));
  assign out_valid = (cnt_q != '0);
  assign count     = cnt_q;

  assign push = in_valid  & in_ready  & ~flush;
  assign pop  = out_valid & out_ready & ~flush;

  always_comb begin
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointers and occupancy; flush clears these but leaves storage intact.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      cnt_q <= '0;
    end else if (flush) begin
      wp    <= '0;
      rp    <= '0;
      cnt_q <= '0;
    end else begin
      if (push) wp <= wp + PTR_W'(1);
      if (pop)  rp <= rp + PTR_W'(1);
      cnt_q <= cnt_d;
    end
  end

  // Entry storage, zeroed only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else if (push) begin
      mem[wp] <= '{pc: in_pc, inst: in_inst};
    end
  end

  // Head is masked to zero when empty so ID never sees stale words.
  always_comb begin
    head = '0;
    if (out_valid) head = mem[rp];
  end

  assign out_pc   = head.pc;
  assign out_inst = head.inst;

endmodule

// File: tb/tb_if_id_queue.sv
// Self-checking bench for if_id_queue: queue-model scoreboard, a table of
// directed vectors, hand-written corner sequences and a random stream.
module tb_if_id_queue;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned INST_W = 32;
  localparam int unsigned DEPTH  = 2;
  localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] in_pc;
  logic [INST_W-1:0] in_inst;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_pc;
  logic [INST_W-1:0] out_inst;
  logic [CNT_W-1:0]  count;

  if_id_queue #(.ADDR_W(ADDR_W), .INST_W(INST_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_inst(out_inst), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } ent_t;

  typedef struct {
    logic              v;
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
    logic              ordy;
    logic              fl;
    int unsigned       e_cnt;
    logic              e_ov;
    logic              e_ir;
    logic [ADDR_W-1:0] e_pc;
    logic [INST_W-1:0] e_inst;
  } vec_t;

  ent_t              q[$];
  logic [ADDR_W-1:0] log_pc[$];
  vec_t              tbl[7];
  int                n_cmp  = 0;
  int                n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare all DUT outputs against the reference queue.
  task automatic check_model();
    int unsigned m;
    logic [ADDR_W-1:0] epc;
    logic [INST_W-1:0] einst;
    m = q.size();
    epc = '0;
    einst = '0;
    if (m != 0) begin
      epc = q[0].pc;
      einst = q[0].inst;
    end
    chk("count", 64'(count), 64'(m));
    chk("out_valid", 64'(out_valid), 64'(m != 0));
    chk("in_ready", 64'(in_ready), 64'(m < DEPTH));
    chk("out_pc", 64'(out_pc), 64'(epc));
    chk("out_inst", 64'(out_inst), 64'(einst));
  endtask

  // Drive one cycle, advance the reference model at the edge, then check.
  task automatic step(input logic v, input logic [ADDR_W-1:0] pc,
                      input logic [INST_W-1:0] inst, input logic ordy, input logic fl);
    logic acc;
    logic pp;
    ent_t e;
    in_valid  = v;
    in_pc     = pc;
    in_inst   = inst;
    out_ready = ordy;
    flush     = fl;
    acc = v && (q.size() < DEPTH) && !fl;
    pp  = (q.size() != 0) && ordy && !fl;
    @(posedge clk);
    #1;
    if (fl) begin
      q.delete();
    end else begin
      if (pp) begin
        e = q.pop_front();
        log_pc.push_back(e.pc);
      end
      if (acc) q.push_back('{pc: pc, inst: inst});
    end
    check_model();
  endtask

  initial begin
    logic [ADDR_W-1:0] pc_ctr;

    tbl[0] = '{1'b1, 32'h100, 32'h0050_0093, 1'b0, 1'b0, 1, 1'b1, 1'b1, 32'h100, 32'h0050_0093};
    tbl[1] = '{1'b0, 32'h0,   32'h0,         1'b1, 1'b0, 0, 1'b0, 1'b1, 32'h0,   32'h0};
    tbl[2] = '{1'b1, 32'h0,   32'h13,        1'b0, 1'b0, 1, 1'b1, 1'b1, 32'h0,   32'h13};
    tbl[3] = '{1'b1, 32'h4,   32'h11,        1'b0, 1'b0, 2, 1'b1, 1'b0, 32'h0,   32'h13};
    tbl[4] = '{1'b1, 32'h8,   32'h12,        1'b0, 1'b0, 2, 1'b1, 1'b0, 32'h0,   32'h13};
    tbl[5] = '{1'b1, 32'h8,   32'h12,        1'b1, 1'b0, 1, 1'b1, 1'b1, 32'h4,   32'h11};
    tbl[6] = '{1'b0, 32'h0,   32'h0,         1'b1, 1'b0, 0, 1'b0, 1'b1, 32'h0,   32'h0};

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_pc = '0; in_inst = '0; out_ready = 1'b0;
    #1;
    check_model();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Latency, drain, fill to full and pop-while-full.
    for (int i = 0; i < 7; i++) begin
      step(tbl[i].v, tbl[i].pc, tbl[i].inst, tbl[i].ordy, tbl[i].fl);
      chk($sformatf("tbl%0d_count", i), 64'(count), 64'(tbl[i].e_cnt));
      chk($sformatf("tbl%0d_out_valid", i), 64'(out_valid), 64'(tbl[i].e_ov));
      chk($sformatf("tbl%0d_in_ready", i), 64'(in_ready), 64'(tbl[i].e_ir));
      chk($sformatf("tbl%0d_out_pc", i), 64'(out_pc), 64'(tbl[i].e_pc));
      chk($sformatf("tbl%0d_out_inst", i), 64'(out_inst), 64'(tbl[i].e_inst));
    end
    chk("bp_log_len", 64'(log_pc.size()), 64'd3);
    chk("bp_log_1", 64'(log_pc[1]), 64'h0);
    chk("bp_log_2", 64'(log_pc[2]), 64'h4);

    // Continuous stream through the wrapping pointers.
    log_pc.delete();
    for (int i = 0; i < 10; i++) begin
      step(1'b1, ADDR_W'(i * 4), INST_W'(32'hA000 + i), 1'b1, 1'b0);
      chk($sformatf("stream_count%0d", i), 64'(count), 64'd1);
    end
    step(1'b0, '0, '0, 1'b1, 1'b0);
    chk("stream_len", 64'(log_pc.size()), 64'd10);
    for (int i = 0; i < 10; i++) begin
      if (i < log_pc.size()) chk($sformatf("stream_pc%0d", i), 64'(log_pc[i]), 64'(i * 4));
    end

    // Flush together with a push at full occupancy.
    log_pc.delete();
    step(1'b1, 32'h30, 32'h3, 1'b0, 1'b0);
    step(1'b1, 32'h34, 32'h4, 1'b0, 1'b0);
    chk("pre_flush_count", 64'(count), 64'd2);
    step(1'b1, 32'h40, 32'h5, 1'b0, 1'b1);
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    for (int i = 0; i < 3; i++) step(1'b0, '0, '0, 1'b1, 1'b0);
    chk("flush_no_40", 64'(log_pc.size()), 64'd0);

    // Asynchronous reset mid-stream while a push is offered.
    step(1'b1, 32'h50, 32'h6, 1'b0, 1'b0);
    in_valid = 1'b1; in_pc = 32'h300; in_inst = 32'h7;
    #3;
    rst = 1'b1;
    #1;
    q.delete();
    chk("rst_async_out_valid", 64'(out_valid), 64'd0);
    chk("rst_async_out_inst", 64'(out_inst), 64'd0);
    chk("rst_async_count", 64'(count), 64'd0);
    chk("rst_async_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    check_model();
    rst = 1'b0;
    step(1'b1, 32'h200, 32'h8, 1'b0, 1'b0);
    chk("rst_first_pc", 64'(out_pc), 64'h200);

    // Random traffic with occasional flushes against the reference model.
    step(1'b0, '0, '0, 1'b1, 1'b1);
    pc_ctr = 32'h1000;
    for (int i = 0; i < 300; i++) begin
      step($urandom_range(0, 3) != 0, pc_ctr, INST_W'($urandom), $urandom_range(0, 2) != 0,
           $urandom_range(0, 24) == 0);
      pc_ctr = pc_ctr + ADDR_W'(4);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/if_id_queue.md
IF_ID_QUEUE -- requirements
Module: if_id_queue

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, meaning the instruction address width.
REQ-002 The block SHALL have parameter INST_W, default 32, meaning the instruction word width.
REQ-003 The block SHALL have parameter DEPTH, default 2, meaning the entry count; legal values are powers of two, >= 2.
REQ-004 clk  input  1  single clock; all state updates on posedge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 flush  input  1  discard all held entries (branch mispredict / exception redirect).
REQ-007 in_valid  input  1  IF offers an entry this cycle.
REQ-008 in_ready  output  1  queue can accept an entry this cycle.
REQ-009 in_pc  input  ADDR_W  PC of offered instruction.
REQ-010 in_inst  input  INST_W  offered instruction word.
REQ-011 out_valid  output  1  head entry valid for ID.
REQ-012 out_ready  input  1  ID consumes the head this cycle.
REQ-013 out_pc  output  ADDR_W  PC of head entry.
REQ-014 out_inst  output  INST_W  instruction word of head entry.
REQ-015 count  output  clog2(DEPTH)+1  number of held entries.

Function
REQ-016 Push SHALL occur on a clock edge when in_valid=1, in_ready=1 and flush=0.
REQ-017 Pop SHALL occur on a clock edge when out_valid=1, out_ready=1 and flush=0.
REQ-018 in_ready SHALL equal (count < DEPTH), with no combinational path from out_ready or in_valid.
REQ-019 out_valid SHALL equal (count != 0), with no combinational path from in_valid.
REQ-020 Storage SHALL be a circular buffer with write pointer wp and read pointer rp, each clog2(DEPTH) bits wide, incrementing modulo DEPTH on push and pop respectively.
REQ-021 Latency SHALL be 1 cycle: an entry pushed at edge N is presented with out_valid=1 in the cycle after edge N.
REQ-022 The queue SHALL NOT bypass: while empty, an entry offered in a cycle is not visible at the outputs in that same cycle.
REQ-023 Simultaneous push and pop with 0 < count < DEPTH SHALL leave count unchanged and advance both pointers.
REQ-024 Simultaneous push and pop at count=0 SHALL NOT occur because out_valid=0; only the push takes effect.
REQ-025 At count=DEPTH, push SHALL NOT occur because in_ready=0, even if a pop occurs in the same cycle; in_ready rises the cycle after that pop.
REQ-026 Entries SHALL leave in push order, with pc and inst always paired.
REQ-027 flush=1 at an edge SHALL set count=0 and rp=wp=0, and SHALL discard any concurrent push or pop.
REQ-028 flush=1 at an edge SHALL NOT clear storage contents; only the pointers and count are cleared.
REQ-029 When out_valid=0, out_pc and out_inst SHALL be driven to all-zero, so ID sees a zero word, never stale data.
REQ-030 A held head entry's out_pc and out_inst SHALL remain stable while out_valid=1 and out_ready=0.
REQ-031 count SHALL be updated at the edge and never exceed DEPTH; pointer wrap SHALL be seamless across all DEPTH slots.

Reset
REQ-032 rst=1 SHALL immediately, without waiting for clk, force count=0, rp=wp=0 and all storage entries to zero.
REQ-033 While rst=1, outputs SHALL be out_valid=0, out_pc=0, out_inst=0 and in_ready=1.
REQ-034 Reset asserted mid-operation SHALL discard all entries, and SHALL take priority over flush and over any push or pop.
REQ-035 After rst deasserts, the first push SHALL be accepted at the next qualifying edge.

Verification
REQ-036 Reset/idle: assert rst asynchronously between edges -> out_valid=0, out_inst=0, count=0 and in_ready=1 before the next edge.
REQ-037 Latency: push pc=0x100, inst=0x00500093 into the empty queue with out_ready=0 -> out_valid=1, out_pc=0x100, out_inst=0x00500093 one cycle later, and count=1.
REQ-038 Full/backpressure: with DEPTH=2 and out_ready=0, offer pc 0x0, 0x4, 0x8 -> only 0x0 and 0x4 are accepted, count=2, in_ready=0, and out_pc stays 0x0.
REQ-039 Stream and wrap: in_valid=1 and out_ready=1 continuously for 10 sequential PCs from 0x0, step 4 -> outputs appear in order 0x0..0x24 with no drop or duplicate, and count is steady at 1 after the first push.
REQ-040 Flush with push: at count=2, assert flush together with a push of pc=0x40 -> next cycle count=0 and out_valid=0, and pc 0x40 never appears.
REQ-041 Reset mid-stream: assert rst at count=1 while pushing -> after release the queue is empty and the next push of pc=0x200 emerges first.
